// File: rtl/dport_hart_resp_pkg.sv
// State encoding, register bundle and address decode ranges for dport_hart_resp.
// Also provides the size-based zero-extension helper for memory reads.
// No ports; imported by dport_hart_resp.
package dport_hart_resp_pkg;

    import river_cfg_pkg::*;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_IREG     = 3'd1;
    localparam logic [2:0] ST_CSR_REQ  = 3'd2;
    localparam logic [2:0] ST_CSR_RESP = 3'd3;
    localparam logic [2:0] ST_MEM_REQ  = 3'd4;
    localparam logic [2:0] ST_MEM_RESP = 3'd5;
    localparam logic [2:0] ST_RESP     = 3'd6;

    // RegAccess address windows on addr[15:0]
    localparam logic [15:0] CSR_ADDR_MAX  = 16'h0FFF;
    localparam logic [15:0] IREG_ADDR_MIN = 16'h1000;
    localparam logic [15:0] IREG_ADDR_MAX = 16'h103F;

    // Only the write flag of the request type matters once the target
    // state is chosen, so the decoded flag is kept instead of the vector.
    typedef struct packed {
        logic [2:0]            state;
        logic                  wr;
        logic [RISCV_ARCH-1:0] addr;
        logic [RISCV_ARCH-1:0] wdata;
        logic [2:0]            size;
        logic [RISCV_ARCH-1:0] rdata;
        logic                  resp_err;
        logic                  haltreq;
        logic                  resumereq;
        logic                  resethaltreq;
        logic                  hartreset;
    } dport_hart_regs_t;

    localparam dport_hart_regs_t DPORT_HART_REG_RESET = '0;

    // size: 0=1B, 1=2B, 2=4B, anything else = full width
    function automatic logic [RISCV_ARCH-1:0] zext_by_size(
        input logic [RISCV_ARCH-1:0] d,
        input logic [2:0]            sz
    );
        logic [RISCV_ARCH-1:0] r;
        case (sz)
            3'd0:    r = {{(RISCV_ARCH-8){1'b0}},  d[7:0]};
            3'd1:    r = {{(RISCV_ARCH-16){1'b0}}, d[15:0]};
            3'd2:    r = {{(RISCV_ARCH-32){1'b0}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage : dport_hart_resp_pkg

// File: rtl/river_cfg_pkg.sv
// Core configuration constants shared with the debug port.
// Holds the architectural register width and the DPortReq_* bit indices
// used to decode dport request types.
package river_cfg_pkg;

    localparam int RISCV_ARCH = 64;

    // Bit positions inside the dport request type vector
    localparam int DPortReq_Write     = 0;
    localparam int DPortReq_RegAccess = 1;
    localparam int DPortReq_MemAccess = 2;
    localparam int DPortReq_Progexec  = 3;
    localparam int DPortReq_Total     = 4;

endpackage : river_cfg_pkg

// File: rtl/types_river_pkg.sv
// Debug-port interconnect bundle types.
// dport_in_type: control bits, request channel and response ready.
// dport_out_type: request ready and response channel.
package types_river_pkg;

    import river_cfg_pkg::*;

    typedef struct packed {
        logic                      haltreq;
        logic                      resumereq;
        logic                      resethaltreq;
        logic                      hartreset;
        logic                      req_valid;
        logic [DPortReq_Total-1:0] dtype;
        logic [RISCV_ARCH-1:0]     addr;
        logic [RISCV_ARCH-1:0]     wdata;
        logic [2:0]                size;
        logic                      resp_ready;
    } dport_in_type;

    typedef struct packed {
        logic                  req_ready;
        logic                  resp_valid;
        logic                  resp_error;
        logic [RISCV_ARCH-1:0] rdata;
    } dport_out_type;

endpackage : types_river_pkg

// File: rtl/dport_hart_resp.sv
// Per-hart debug-port responder: decodes one dport request into an integer
// regfile, CSR or memory access and returns a single response.
// Ports: i_dporti/o_dporto to the interconnect, registered control copies,
// regfile port (o_ireg_*), CSR req/resp channel, memory req/resp channel.
// Latency: regfile access 2 cycles accept-to-resp_valid; CSR/mem are backend
// dependent, bounded by the watchdog. One request in flight; req_ready only in IDLE.
module dport_hart_resp
    import river_cfg_pkg::*;
    import types_river_pkg::*;
    import dport_hart_resp_pkg::*;
#(
    parameter logic async_reset = 1'b1,
    parameter int   TMO_WIDTH   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  dport_in_type          i_dporti,
    output dport_out_type         o_dporto,
    output logic                  o_haltreq,
    output logic                  o_resumereq,
    output logic                  o_resethaltreq,
    output logic                  o_hartreset,
    output logic [5:0]            o_ireg_addr,
    output logic                  o_ireg_wena,
    output logic [RISCV_ARCH-1:0] o_ireg_wdata,
    input  logic [RISCV_ARCH-1:0] i_ireg_rdata,
    output logic                  o_csr_req_valid,
    input  logic                  i_csr_req_ready,
    output logic                  o_csr_req_write,
    output logic [11:0]           o_csr_req_addr,
    output logic [RISCV_ARCH-1:0] o_csr_req_data,
    input  logic                  i_csr_resp_valid,
    input  logic                  i_csr_resp_exception,
    input  logic [RISCV_ARCH-1:0] i_csr_resp_data,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic                  o_mem_req_write,
    output logic [RISCV_ARCH-1:0] o_mem_req_addr,
    output logic [RISCV_ARCH-1:0] o_mem_req_wdata,
    output logic [2:0]            o_mem_req_size,
    input  logic                  i_mem_resp_valid,
    input  logic                  i_mem_resp_error,
    input  logic [RISCV_ARCH-1:0] i_mem_resp_data
);

    dport_hart_regs_t     r_q, r_d;
    // Watchdog width is a module parameter, so it lives outside the bundle
    logic [TMO_WIDTH-1:0] tmo_q, tmo_d;

    logic        req_fire;
    logic        tmo_expired;
    logic        is_mem;
    logic        is_reg;
    logic [15:0] reg_addr;

    always_comb begin
        r_d   = r_q;
        tmo_d = tmo_q;

        // Control copies track the interconnect regardless of FSM state
        r_d.haltreq      = i_dporti.haltreq;
        r_d.resumereq    = i_dporti.resumereq;
        r_d.resethaltreq = i_dporti.resethaltreq;
        r_d.hartreset    = i_dporti.hartreset;

        req_fire    = i_dporti.req_valid && (r_q.state == ST_IDLE);
        tmo_expired = &tmo_q;
        // A Progexec request is never serviced here, whatever else is set
        is_mem      = i_dporti.dtype[DPortReq_MemAccess] && !i_dporti.dtype[DPortReq_Progexec];
        is_reg      = i_dporti.dtype[DPortReq_RegAccess] && !i_dporti.dtype[DPortReq_Progexec];
        reg_addr    = i_dporti.addr[15:0];

        case (r_q.state)
            ST_IDLE: begin
                if (req_fire) begin
                    r_d.wr       = i_dporti.dtype[DPortReq_Write];
                    r_d.addr     = i_dporti.addr;
                    r_d.wdata    = i_dporti.wdata;
                    r_d.size     = i_dporti.size;
                    r_d.rdata    = '0;
                    r_d.resp_err = 1'b0;
                    tmo_d        = '0;
                    if (is_mem) begin
                        r_d.state = ST_MEM_REQ;
                    end else if (is_reg && (reg_addr <= CSR_ADDR_MAX)) begin
                        r_d.state = ST_CSR_REQ;
                    end else if (is_reg && (reg_addr >= IREG_ADDR_MIN)
                                        && (reg_addr <= IREG_ADDR_MAX)) begin
                        r_d.state = ST_IREG;
                    end else begin
                        r_d.resp_err = 1'b1;
                        r_d.state    = ST_RESP;
                    end
                end
            end
            ST_IREG: begin
                r_d.rdata = i_ireg_rdata;
                r_d.state = ST_RESP;
            end
            ST_CSR_REQ: begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_expired) begin
                    r_d.resp_err = 1'b1;
                    r_d.state    = ST_RESP;
                end else if (i_csr_req_ready) begin
                    r_d.state = ST_CSR_RESP;
                end
            end
            ST_CSR_RESP: begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_expired) begin
                    r_d.resp_err = 1'b1;
                    r_d.state    = ST_RESP;
                end else if (i_csr_resp_valid) begin
                    r_d.rdata    = i_csr_resp_exception ? '0 : i_csr_resp_data;
                    r_d.resp_err = i_csr_resp_exception;
                    r_d.state    = ST_RESP;
                end
            end
            ST_MEM_REQ: begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_expired) begin
                    r_d.resp_err = 1'b1;
                    r_d.state    = ST_RESP;
                end else if (i_mem_req_ready) begin
                    r_d.state = ST_MEM_RESP;
                end
            end
            ST_MEM_RESP: begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_expired) begin
                    r_d.resp_err = 1'b1;
                    r_d.state    = ST_RESP;
                end else if (i_mem_resp_valid) begin
                    r_d.rdata    = i_mem_resp_error ? '0
                                 : zext_by_size(i_mem_resp_data, r_q.size);
                    r_d.resp_err = i_mem_resp_error;
                    r_d.state    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_dporti.resp_ready) begin
                    r_d.state = ST_IDLE;
                end
            end
            default: begin
                r_d.state = ST_IDLE;
            end
        endcase

        // Hart reset wins over everything: abandon the request silently
        if (i_dporti.hartreset) begin
            r_d.state    = ST_IDLE;
            r_d.rdata    = '0;
            r_d.resp_err = 1'b0;
            tmo_d        = '0;
        end
    end

    generate
        if (async_reset) begin : g_async_rst
            always_ff @(posedge i_clk or negedge i_nrst) begin
                if (!i_nrst) begin
                    r_q   <= DPORT_HART_REG_RESET;
                    tmo_q <= '0;
                end else begin
                    r_q   <= r_d;
                    tmo_q <= tmo_d;
                end
            end
        end else begin : g_sync_rst
            always_ff @(posedge i_clk) begin
                if (!i_nrst) begin
                    r_q   <= DPORT_HART_REG_RESET;
                    tmo_q <= '0;
                end else begin
                    r_q   <= r_d;
                    tmo_q <= tmo_d;
                end
            end
        end
    endgenerate

    always_comb begin
        o_dporto.req_ready  = (r_q.state == ST_IDLE);
        o_dporto.resp_valid = (r_q.state == ST_RESP);
        o_dporto.resp_error = r_q.resp_err;
        o_dporto.rdata      = r_q.rdata;
    end

    assign o_haltreq      = r_q.haltreq;
    assign o_resumereq    = r_q.resumereq;
    assign o_resethaltreq = r_q.resethaltreq;
    assign o_hartreset    = r_q.hartreset;

    // IREG lasts exactly one cycle, so the strobe is a single-cycle pulse
    assign o_ireg_addr  = r_q.addr[5:0];
    assign o_ireg_wena  = (r_q.state == ST_IREG) && r_q.wr;
    assign o_ireg_wdata = r_q.wdata;

    assign o_csr_req_valid = (r_q.state == ST_CSR_REQ);
    assign o_csr_req_write = r_q.wr;
    assign o_csr_req_addr  = r_q.addr[11:0];
    assign o_csr_req_data  = r_q.wdata;

    assign o_mem_req_valid = (r_q.state == ST_MEM_REQ);
    assign o_mem_req_write = r_q.wr;
    assign o_mem_req_addr  = r_q.addr;
    assign o_mem_req_wdata = r_q.wdata;
    assign o_mem_req_size  = r_q.size;

endmodule : dport_hart_resp

// File: tb/tb_dport_hart_resp.sv
// Directed self-checking bench for dport_hart_resp.
// Drives and samples 1ns after the rising clock edge.
// All expected values are hand-computed constants.
module tb_dport_hart_resp;

    import river_cfg_pkg::*;
    import types_river_pkg::*;

    localparam logic [DPortReq_Total-1:0] DT_WR   = DPortReq_Total'(1) << DPortReq_Write;
    localparam logic [DPortReq_Total-1:0] DT_REG  = DPortReq_Total'(1) << DPortReq_RegAccess;
    localparam logic [DPortReq_Total-1:0] DT_MEM  = DPortReq_Total'(1) << DPortReq_MemAccess;
    localparam logic [DPortReq_Total-1:0] DT_PROG = DPortReq_Total'(1) << DPortReq_Progexec;

    logic                  clk;
    logic                  nrst;
    dport_in_type          dporti;
    dport_out_type         dporto;
    logic                  haltreq, resumereq, resethaltreq, hartreset;
    logic [5:0]            ireg_addr;
    logic                  ireg_wena;
    logic [RISCV_ARCH-1:0] ireg_wdata, ireg_rdata;
    logic                  csr_req_valid, csr_req_ready, csr_req_write;
    logic [11:0]           csr_req_addr;
    logic [RISCV_ARCH-1:0] csr_req_data;
    logic                  csr_resp_valid, csr_resp_exception;
    logic [RISCV_ARCH-1:0] csr_resp_data;
    logic                  mem_req_valid, mem_req_ready, mem_req_write;
    logic [RISCV_ARCH-1:0] mem_req_addr, mem_req_wdata;
    logic [2:0]            mem_req_size;
    logic                  mem_resp_valid, mem_resp_error;
    logic [RISCV_ARCH-1:0] mem_resp_data;

    int n_chk  = 0;
    int n_pass = 0;

    dport_hart_resp #(.async_reset(1'b1), .TMO_WIDTH(8)) dut (
        .i_clk                (clk),
        .i_nrst               (nrst),
        .i_dporti             (dporti),
        .o_dporto             (dporto),
        .o_haltreq            (haltreq),
        .o_resumereq          (resumereq),
        .o_resethaltreq       (resethaltreq),
        .o_hartreset          (hartreset),
        .o_ireg_addr          (ireg_addr),
        .o_ireg_wena          (ireg_wena),
        .o_ireg_wdata         (ireg_wdata),
        .i_ireg_rdata         (ireg_rdata),
        .o_csr_req_valid      (csr_req_valid),
        .i_csr_req_ready      (csr_req_ready),
        .o_csr_req_write      (csr_req_write),
        .o_csr_req_addr       (csr_req_addr),
        .o_csr_req_data       (csr_req_data),
        .i_csr_resp_valid     (csr_resp_valid),
        .i_csr_resp_exception (csr_resp_exception),
        .i_csr_resp_data      (csr_resp_data),
        .o_mem_req_valid      (mem_req_valid),
        .i_mem_req_ready      (mem_req_ready),
        .o_mem_req_write      (mem_req_write),
        .o_mem_req_addr       (mem_req_addr),
        .o_mem_req_wdata      (mem_req_wdata),
        .o_mem_req_size       (mem_req_size),
        .i_mem_resp_valid     (mem_resp_valid),
        .i_mem_resp_error     (mem_resp_error),
        .i_mem_resp_data      (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; returns just after the accepting edge
    task automatic send(input logic [DPortReq_Total-1:0] dt, input logic [63:0] a,
                        input logic [63:0] wd, input logic [2:0] sz);
        dporti.req_valid = 1'b1;
        dporti.dtype     = dt;
        dporti.addr      = a;
        dporti.wdata     = wd;
        dporti.size      = sz;
        tick();
        dporti.req_valid = 1'b0;
    endtask

    // n = edges after the accepting edge until resp_valid (bounded by max)
    task automatic wait_resp(input int max, output int n);
        n = 0;
        while (!dporto.resp_valid && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic finish_resp();
        dporti.resp_ready = 1'b1;
        tick();
        dporti.resp_ready = 1'b0;
    endtask

    initial begin
        int  n;
        logic seen;

        nrst               = 1'b0;
        dporti             = '0;
        ireg_rdata         = '0;
        csr_req_ready      = 1'b0;
        csr_resp_valid     = 1'b0;
        csr_resp_exception = 1'b0;
        csr_resp_data      = '0;
        mem_req_ready      = 1'b0;
        mem_resp_valid     = 1'b0;
        mem_resp_error     = 1'b0;
        mem_resp_data      = '0;
        tick();
        tick();

        // Reset state
        chk("rst_req_ready", dporto.req_ready, 1);
        chk("rst_outs", {dporto.resp_valid, dporto.resp_error, |dporto.rdata, csr_req_valid,
                         mem_req_valid, ireg_wena, haltreq, resumereq, resethaltreq, hartreset,
                         |mem_req_addr, |ireg_addr, csr_req_write, mem_req_write}, 0);
        nrst = 1'b1;
        tick();

        // Regfile read 0x1005
        ireg_rdata = 64'h1234;
        send(DT_REG, 64'h1005, 64'h0, 3'd3);
        chk("ireg_addr", ireg_addr, 5);
        chk("ireg_rd_wena", ireg_wena, 0);
        wait_resp(10, n);
        chk("ireg_lat", n + 1, 2);
        chk("ireg_rdata", dporto.rdata, 64'h1234);
        chk("ireg_err_rdy", {dporto.resp_error, dporto.req_ready}, 0);
        finish_resp();
        chk("ireg_idle", {dporto.req_ready, dporto.resp_valid}, 2'b10);

        // Regfile write 0x101F: one-cycle strobe
        send(DT_REG | DT_WR, 64'h101F, 64'hDEAD, 3'd3);
        chk("iwr_strobe", {ireg_wena, ireg_addr}, {1'b1, 6'd31});
        chk("iwr_wdata", ireg_wdata, 64'hDEAD);
        tick();
        chk("iwr_pulse_end", {ireg_wena, dporto.resp_valid}, 2'b01);
        finish_resp();

        // CSR write 0x300 with ready delayed 3 cycles
        send(DT_REG | DT_WR, 64'h0300, 64'hA, 3'd3);
        for (int i = 0; i < 3; i++) begin
            chk("csr_hold", {csr_req_valid, csr_req_write, csr_req_addr, csr_req_data[31:0]},
                {1'b1, 1'b1, 12'h300, 32'hA});
            tick();
        end
        chk("csr_hold_last", {csr_req_valid, csr_req_addr}, {1'b1, 12'h300});
        csr_req_ready = 1'b1;
        tick();
        csr_req_ready = 1'b0;
        chk("csr_req_drop", csr_req_valid, 0);
        csr_resp_valid = 1'b1;
        csr_resp_data  = 64'h55;
        tick();
        csr_resp_valid = 1'b0;
        chk("csr_resp", {dporto.resp_valid, dporto.resp_error}, 2'b10);
        chk("csr_rdata", dporto.rdata, 64'h55);
        finish_resp();

        // Memory byte read at 0x80000001
        mem_req_ready = 1'b1;
        send(DT_MEM, 64'h8000_0001, 64'h0, 3'd0);
        chk("mem_req", {mem_req_valid, mem_req_write, mem_req_size}, {1'b1, 1'b0, 3'd0});
        chk("mem_addr", mem_req_addr, 64'h8000_0001);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hFFFF_FFFF_FFFF_FFAB;
        tick();
        mem_resp_valid = 1'b0;
        chk("mem_b_resp", {dporto.resp_valid, dporto.resp_error}, 2'b10);
        chk("mem_b_rdata", dporto.rdata, 64'hAB);
        finish_resp();

        // Memory halfword read
        send(DT_MEM, 64'h8000_0002, 64'h0, 3'd1);
        tick();
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        chk("mem_h_rdata", dporto.rdata, 64'hFFAB);
        finish_resp();

        // Memory error -> error=1, rdata=0
        send(DT_MEM, 64'h8000_0008, 64'h0, 3'd3);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_error = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_error = 1'b0;
        chk("mem_err", {dporto.resp_valid, dporto.resp_error}, 2'b11);
        chk("mem_err_rdata", dporto.rdata, 0);
        finish_resp();

        // Watchdog: no backend response
        send(DT_MEM, 64'h100, 64'h0, 3'd3);
        wait_resp(400, n);
        chk("tmo_resp", {dporto.resp_valid, dporto.resp_error}, 2'b11);
        chk("tmo_lat_window", (n + 1 >= 255) && (n + 1 <= 258), 1);
        chk("tmo_rdata", dporto.rdata, 0);
        finish_resp();
        for (int i = n + 2; i < 300; i++) tick();
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        chk("tmo_late_ignored", {dporto.resp_valid, dporto.req_ready}, 2'b01);

        // Undecoded RegAccess 0x2000 with resp_ready held low
        send(DT_REG, 64'h2000, 64'h0, 3'd3);
        wait_resp(10, n);
        chk("bad_addr", {dporto.resp_valid, dporto.resp_error}, 2'b11);
        chk("bad_addr_rdata", dporto.rdata, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bad_hold", {dporto.resp_valid, dporto.req_ready, dporto.resp_error, |dporto.rdata},
                4'b1010);
        end
        finish_resp();

        // Progexec is refused
        send(DT_PROG, 64'h1000, 64'h0, 3'd3);
        wait_resp(10, n);
        chk("progexec_err", {dporto.resp_valid, dporto.resp_error}, 2'b11);
        finish_resp();

        // Control copies: one-cycle latency
        dporti.haltreq = 1'b1;
        chk("halt_pre", haltreq, 0);
        tick();
        chk("halt_copy", {haltreq, resumereq}, 2'b10);
        dporti.haltreq      = 1'b0;
        dporti.resumereq    = 1'b1;
        dporti.resethaltreq = 1'b1;
        tick();
        chk("resume_copy", {haltreq, resumereq, resethaltreq}, 3'b011);
        dporti.resumereq    = 1'b0;
        dporti.resethaltreq = 1'b0;
        tick();

        // Hart reset during MEM_RESP
        send(DT_MEM, 64'h200, 64'h0, 3'd3);
        tick();
        chk("hr_in_resp", {mem_req_valid, dporto.req_ready}, 0);
        dporti.hartreset = 1'b1;
        tick();
        chk("hr_copy_idle", {hartreset, dporto.req_ready, dporto.resp_valid}, 3'b110);
        dporti.hartreset = 1'b0;
        mem_resp_valid   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            mem_resp_valid = 1'b0;
            seen = seen | dporto.resp_valid;
        end
        chk("hr_no_resp", seen, 0);

        // Reset mid-transaction
        send(DT_MEM, 64'h300, 64'h0, 3'd3);
        tick();
        nrst = 1'b0;
        #2;
        chk("arst_mid", {dporto.req_ready, dporto.resp_valid}, 2'b10);
        nrst = 1'b1;
        tick();
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        chk("arst_no_resp", {dporto.resp_valid, dporto.req_ready}, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_dport_hart_resp
